add_sub_seq: RTL
================

// Module: add_sub_seq
// PURPOSE
//  Operand sequencer and result register wrapped around the combinational add_sub datapath.
//  - Accepts one operation at a time over a valid/ready handshake.
//  - Drives registered operands and mode into add_sub, then captures RES/CARRY and derives flags.
//  - Keeps a running accumulator and returns each result over a second valid/ready handshake.
// PARAMETERS
//  WIDTH  4  operand/result width; must match the add_sub instance width
// PORTS
//  CLK        in   1      single clock, rising edge
//  RST_N      in   1      asynchronous reset, active low
//  OP_VALID   in   1      operation request valid
//  OP_READY   out  1      sequencer can accept an operation
//  OP_A       in   WIDTH  operand A (ignored when OP_ACC=1)
//  OP_B       in   WIDTH  operand B
//  OP_SUB     in   1      0: A+B, 1: A-B
//  OP_ACC     in   1      1: use accumulator ACC as operand A
//  ACC_CLR    in   1      synchronous accumulator clear
//  ADD_A      out  WIDTH  to add_sub A (registered)
//  ADD_B      out  WIDTH  to add_sub B (registered)
//  ADD_CIN    out  1      to add_sub C_IN (registered, = OP_SUB)
//  ADD_RES    in   WIDTH  from add_sub RES
//  ADD_CARRY  in   1      from add_sub CARRY (sub: 1 = no borrow)
//  RES_VALID  out  1      result valid
//  RES_READY  in   1      consumer accepts result
//  RES_DATA   out  WIDTH  captured result
//  RES_CARRY  out  1      captured carry/no-borrow
//  RES_OVF    out  1      signed two's-complement overflow
//  RES_ZERO   out  1      RES_DATA == 0
//  ACC        out  WIDTH  accumulator = last captured result
// BEHAVIOUR
//  Reset (RST_N low, any time, async): state=IDLE; all outputs 0 except OP_READY=1; in-flight op is dropped.
//  FSM states: IDLE, EXEC, HOLD.
//  - IDLE: OP_READY=1. On OP_VALID && OP_READY at edge k:
//      ADD_A <= OP_ACC ? ACC : OP_A; ADD_B <= OP_B; ADD_CIN <= OP_SUB; go to EXEC.
//  - EXEC: OP_READY=0; one cycle for add_sub to settle. At edge k+1:
//      RES_DATA <= ADD_RES; RES_CARRY <= ADD_CARRY; ACC <= ADD_RES; go to HOLD.
//  - HOLD: RES_VALID=1; outputs stable until RES_READY=1 at an edge, then go to IDLE.
//      RES_VALID is 0 in IDLE and EXEC.
//  Latency: RES_VALID rises 2 edges after acceptance; min 3 cycles/op with RES_READY tied high.
//  Flags: Beff = ADD_CIN ? ~ADD_B : ADD_B; RES_OVF = (A[W-1]==Beff[W-1]) && (RES[W-1]!=A[W-1]).
//    RES_ZERO computed from the captured RES_DATA. All flags hold with RES_DATA until the next capture.
//  Result arithmetic is done by add_sub, modulo 2^WIDTH; this block only selects operands and captures.
//  ACC_CLR: ACC <= 0 in any state.
//    If it coincides with the EXEC capture edge, the clear wins for ACC; RES_* still capture normally.
//  OP_ACC with ACC_CLR on the acceptance edge: ADD_A takes the pre-clear ACC value.
//  OP_VALID while not IDLE: ignored (OP_READY=0); the requester must hold the op.
//  RES_READY high outside HOLD: no effect.
// TESTING (WIDTH=4; each op then RES_READY=1)
//  1 add: A=0011 B=0011 SUB=0 -> RES=0110 CARRY=0 OVF=0, RES_VALID 2 edges after accept.
//  2 carry/sub: A=1111 B=0101 SUB=0 -> 0100 C=1;
//      A=1100 B=1001 SUB=1 -> 0011 C=1;
//      A=1100 B=1110 SUB=1 -> 1110 C=0.
//  3 overflow/zero: 0111+0001 -> 1000 OVF=1;
//      A=0101 B=0101 SUB=1 -> 0000 ZERO=1 C=1.
//  4 accumulate: clear, then OP_ACC=1 with B=0011 three times -> ACC 0011, 0110, 1001.
//      ACC_CLR on the capture edge -> ACC=0, RES_DATA=1100.
//  5 backpressure: hold RES_READY=0 for 5 cycles -> RES_* stable, OP_READY=0, a second OP_VALID is not accepted.
//  6 reset mid-EXEC: RST_N low asynchronously -> RES_VALID=0, ACC=0, OP_READY=1 immediately; next op runs normally.

Source files
------------

// File: rtl/add_sub_seq.sv
// Operand sequencer and result register around an external combinational add_sub datapath.
// One operation in flight at a time: accept, let add_sub settle for a cycle, then hold the result.
module add_sub_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             op_acc,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_res,
    input  logic             add_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_ovf,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] add_a_q, add_b_q;
    logic             add_cin_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_carry_q, res_ovf_q, res_zero_q;
    logic [WIDTH-1:0] acc_q;

    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] b_eff;
    logic             ovf_calc;

    assign accept  = op_valid && (state_q == IDLE);
    assign capture = (state_q == EXEC);

    // Subtraction is A + ~B + 1, so overflow is judged against the inverted B.
    assign b_eff    = add_cin_q ? ~add_b_q : add_b_q;
    assign ovf_calc = (add_a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (add_res[WIDTH-1] != add_a_q[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_valid) state_d = EXEC;
            EXEC:    state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand A samples the accumulator before any same-edge clear takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
        end else if (accept) begin
            add_a_q   <= op_acc ? acc_q : op_a;
            add_b_q   <= op_b;
            add_cin_q <= op_sub;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
        end else if (capture) begin
            res_data_q  <= add_res;
            res_carry_q <= add_carry;
            res_ovf_q   <= ovf_calc;
            res_zero_q  <= (add_res == '0);
        end
    end

    // Clear has priority over the capture update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (capture) begin
            acc_q <= add_res;
        end
    end

    assign op_ready  = (state_q == IDLE);
    assign res_valid = (state_q == HOLD);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_ovf   = res_ovf_q;
    assign res_zero  = res_zero_q;
    assign acc       = acc_q;

endmodule
